// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word-aligned request at a time, waits for
// the response with a timeout, and holds the fetched word until decode takes it.
module instr_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q,     state_d;
  logic [31:0] addr_q,      addr_d;
  logic        misalign_q,  misalign_d;
  logic [31:0] inst_q,      inst_d;
  logic        fetch_err_q, fetch_err_d;
  logic        drop_q,      drop_d;
  logic [7:0]  cnt_q,       cnt_d;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      misalign_q  <= 1'b0;
      inst_q      <= NOP_INST;
      fetch_err_q <= 1'b0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      misalign_q  <= misalign_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    misalign_d  = misalign_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_en && !flush) begin
          state_d    = REQ;
          addr_d     = {pc[31:2], 2'b00};
          misalign_d = |pc[1:0];
        end
      end

      REQ: begin
        if (misalign_q) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d     = HOLD;
            inst_d      = NOP_INST;
            fetch_err_d = 1'b1;
          end
        end else if (imem_gnt) begin
          // A grant cannot be taken back; a simultaneous flush just marks the
          // coming response for discard.
          state_d = WAIT;
          cnt_d   = '0;
          drop_d  = flush;
        end else if (flush) begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || flush) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d     = HOLD;
            inst_d      = imem_err ? NOP_INST : imem_rdata;
            fetch_err_d = imem_err;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush) drop_d = 1'b1;
          if (cnt_q + 8'd1 == TIMEOUT_C) begin
            if (drop_q || flush) begin
              state_d = IDLE;
              drop_d  = 1'b0;
            end else begin
              state_d     = HOLD;
              inst_d      = NOP_INST;
              fetch_err_d = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (inst_ready) begin
          if (fetch_en) begin
            state_d    = REQ;
            addr_d     = {pc[31:2], 2'b00};
            misalign_d = |pc[1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == REQ) && !misalign_q;
    imem_addr  = addr_q;
    inst       = inst_q;
    inst_valid = (state_q == HOLD);
    fetch_err  = fetch_err_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a sequential driver plays PC source and memory, a
// monitor compares every consumed instruction against a queue of expectations.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        fetch_err;

  instr_fetch #(.NOP_INST(NOP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Outcome of one fetch: misaligned, timed out or errored fetches yield NOP with error.
  function automatic exp_t model(input logic [31:0] p, input int rv_dly, input bit err,
                                 input logic [31:0] rdata);
    exp_t r;
    if (p[1:0] != 2'b00 || rv_dly >= TO || err) begin
      r.inst = NOP;
      r.err  = 1'b1;
    end else begin
      r.inst = rdata;
      r.err  = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_fetch(input logic [31:0] p);
    pc       = p;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
  endtask

  // Entered with the DUT in REQ; leaves it in HOLD.
  task automatic serve(input logic [31:0] p, input int gnt_dly, input int rv_dly,
                       input bit err, input logic [31:0] rdata);
    exp_q.push_back(model(p, rv_dly, err, rdata));
    if (p[1:0] != 2'b00) begin
      check1("req_low_misaligned", imem_req, 1'b0);
      tick();
    end else begin
      for (int g = 0; g <= gnt_dly; g++) begin
        check1("req_high", imem_req, 1'b1);
        check("req_addr", imem_addr, {p[31:2], 2'b00});
        if (g == gnt_dly) imem_gnt = 1'b1;
        tick();
      end
      imem_gnt = 1'b0;
      if (rv_dly < TO) begin
        for (int w = 0; w <= rv_dly; w++) begin
          check1("no_valid_in_wait", inst_valid, 1'b0);
          check1("req_low_in_wait", imem_req, 1'b0);
          if (w == rv_dly) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rdata;
            imem_err    = err;
          end
          tick();
        end
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
      end else begin
        for (int w = 0; w < TO; w++) begin
          check1("no_valid_before_timeout", inst_valid, 1'b0);
          tick();
        end
        // Late response lands in HOLD and must not disturb the held word.
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
        tick();
        imem_rvalid = 1'b0;
      end
    end
    check1("valid_in_hold", inst_valid, 1'b1);
  endtask

  task automatic consume(input int hold_cyc);
    repeat (hold_cyc) tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check1("idle_after_consume", inst_valid, 1'b0);
  endtask

  // Monitor: compares on each handshake and checks HOLD stability.
  initial begin
    logic        pv;
    logic [31:0] pi;
    logic        pe;
    logic        pleft;
    exp_t        e;
    pv = 1'b0; pi = '0; pe = 1'b0; pleft = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pv = 1'b0;
        continue;
      end
      if (inst_valid) begin
        if (pv && !pleft) begin
          check("hold_inst_stable", inst, pi);
          check1("hold_err_stable", fetch_err, pe);
        end
        check1("no_req_in_hold", imem_req, 1'b0);
        if (inst_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_inst_valid", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("inst", inst, e.inst);
            check1("fetch_err", fetch_err, e.err);
          end
        end else if (flush) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      pv    = inst_valid;
      pi    = inst;
      pe    = fetch_err;
      pleft = inst_ready | flush;
    end
  end

  initial begin
    logic [31:0] p;
    int          gd, rd, hc;
    bit          er;

    repeat (2) tick();
    check1("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst", inst, NOP);
    check1("rst_valid", inst_valid, 1'b0);
    check1("rst_err", fetch_err, 1'b0);
    rst = 1'b1;
    tick();

    // Minimum-latency fetch, then held for 5 cycles and consumed back-to-back.
    start_fetch(32'h100);
    serve(32'h100, 0, 0, 1'b0, 32'h00500093);
    repeat (5) tick();
    check("held_after_5", inst, 32'h00500093);
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    pc         = 32'h104;
    tick();
    inst_ready = 1'b0;
    fetch_en   = 1'b0;
    serve(32'h104, 1, 2, 1'b0, 32'h00108113);
    consume(0);

    // Misaligned pc.
    start_fetch(32'h102);
    serve(32'h102, 0, 0, 1'b0, 32'h0);
    consume(1);

    // Timeout, and the last cycle before it.
    start_fetch(32'h200);
    serve(32'h200, 0, TO, 1'b0, 32'h0);
    consume(2);
    start_fetch(32'h204);
    serve(32'h204, 0, TO - 1, 1'b0, 32'hCAFE0001);
    consume(0);

    // Bus error.
    start_fetch(32'h208);
    serve(32'h208, 2, 1, 1'b1, 32'h12345678);
    consume(0);

    // Flush in WAIT, response two cycles later.
    start_fetch(32'h300);
    check1("req_before_flush", imem_req, 1'b1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("no_valid_after_flush", inst_valid, 1'b0);
      check1("no_req_after_flush", imem_req, 1'b0);
      tick();
    end
    start_fetch(32'h304);
    serve(32'h304, 0, 1, 1'b0, 32'h00a00113);
    consume(0);

    // Flush together with the response.
    start_fetch(32'h308);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h11111111;
    flush       = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    flush       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check1("no_valid_flush_rvalid", inst_valid, 1'b0);
      tick();
    end

    // Flush in REQ before grant.
    start_fetch(32'h30C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check1("req_dropped_by_flush", imem_req, 1'b0);
    check1("no_valid_flush_req", inst_valid, 1'b0);

    // Flush in HOLD without consumption.
    start_fetch(32'h310);
    serve(32'h310, 0, 0, 1'b0, 32'h22222222);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check1("hold_flushed", inst_valid, 1'b0);

    // Flush with ready and fetch_en in HOLD: consumed, then IDLE.
    start_fetch(32'h314);
    serve(32'h314, 0, 0, 1'b0, 32'h33333333);
    inst_ready = 1'b1;
    flush      = 1'b1;
    fetch_en   = 1'b1;
    pc         = 32'h400;
    tick();
    inst_ready = 1'b0;
    flush      = 1'b0;
    fetch_en   = 1'b0;
    check1("flush_beats_fetch_req", imem_req, 1'b0);
    check1("flush_beats_fetch_valid", inst_valid, 1'b0);

    // Reset in WAIT, then a stray response.
    start_fetch(32'h500);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #1 rst = 1'b0;
    #1;
    check1("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_inst", inst, NOP);
    check1("mid_rst_valid", inst_valid, 1'b0);
    check1("mid_rst_err", fetch_err, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h44444444;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("no_valid_after_rst", inst_valid, 1'b0);
      tick();
    end

    // Randomized fetches.
    for (int n = 0; n < 40; n++) begin
      p = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) p[1:0] = 2'($urandom_range(1, 3));
      gd = int'($urandom_range(0, 3));
      rd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2))
                                       : int'($urandom_range(0, 4));
      er = ($urandom_range(0, 4) == 0);
      hc = int'($urandom_range(0, 3));
      start_fetch(p);
      serve(p, gd, rd, er, $urandom);
      consume(hc);
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: NOP_INST, 32'h00000013, instruction word presented on error, misalignment or timeout.
REQ-002 Parameter: TIMEOUT, 16, maximum cycles spent in WAIT before a fetch is aborted; legal range 1..255.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: pc  in  32  next fetch address from the PC updater.
REQ-006 Port: fetch_en  in  1  permits a new fetch to start.
REQ-007 Port: flush  in  1  discards any in-flight or held instruction.
REQ-008 Port: imem_req  out  1  memory request strobe.
REQ-009 Port: imem_addr  out  32  word-aligned fetch address.
REQ-010 Port: imem_gnt  in  1  memory accepted the request.
REQ-011 Port: imem_rvalid  in  1  read data valid.
REQ-012 Port: imem_rdata  in  32  read data.
REQ-013 Port: imem_err  in  1  bus error; qualified by imem_rvalid.
REQ-014 Port: inst  out  32  instruction word to the decoder and immediate generator.
REQ-015 Port: inst_valid  out  1  inst holds a valid instruction.
REQ-016 Port: inst_ready  in  1  decode stage consumes inst this cycle.
REQ-017 Port: fetch_err  out  1  the held inst is the result of an error, misalignment or timeout.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and HOLD.
REQ-019 IDLE with fetch_en=1 and flush=0 SHALL latch addr_q={pc[31:2],2'b00} and misalign_q=(pc[1:0]!=0), then go to REQ.
REQ-020 REQ with misalign_q=1 SHALL leave imem_req low, load inst=NOP_INST and fetch_err=1, and go to HOLD on the next edge.
REQ-021 REQ with misalign_q=0 SHALL drive imem_req=1 and imem_addr=addr_q, both held stable until imem_gnt=1.
REQ-022 The transition from REQ to WAIT SHALL occur on the edge at which imem_gnt=1; the timeout counter clears on that edge.
REQ-023 In WAIT, imem_rvalid=1 with imem_err=0 SHALL load inst=imem_rdata and fetch_err=0, then go to HOLD.
REQ-024 In WAIT, imem_rvalid=1 with imem_err=1 SHALL load inst=NOP_INST and fetch_err=1, then go to HOLD.
REQ-025 Each WAIT cycle without imem_rvalid SHALL increment an 8-bit counter.
REQ-026 When the counter reaches TIMEOUT, the block SHALL load NOP_INST with fetch_err=1 and go to HOLD.
REQ-027 A response arriving after a timeout SHALL be ignored.
REQ-028 inst_valid SHALL equal (state==HOLD); minimum latency from fetch_en to inst_valid is 3 cycles (IDLE->REQ->WAIT->HOLD with gnt and rvalid each in the first possible cycle).
REQ-029 In HOLD, inst and fetch_err SHALL remain stable until inst_ready=1.
REQ-030 On HOLD with inst_ready=1, if fetch_en=1 the block SHALL re-latch pc and go directly to REQ (back-to-back fetch); otherwise it SHALL go to IDLE.
REQ-031 Flush in IDLE or REQ SHALL return to IDLE; a request already granted is not withdrawn.
REQ-032 Flush in HOLD SHALL drop inst_valid on the next edge and return to IDLE.
REQ-033 Flush in WAIT SHALL set drop_q; the pending response, when it arrives, SHALL be discarded and the block SHALL return to IDLE without asserting inst_valid.
REQ-034 Flush coinciding with imem_rvalid in WAIT SHALL discard that response.
REQ-035 Flush coinciding with inst_ready in HOLD SHALL count as consumption, then go to IDLE (flush has priority over fetch_en).
REQ-036 At most one request SHALL be outstanding; imem_req is low in WAIT, HOLD and IDLE.
REQ-037 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-038 rst=0 SHALL asynchronously force state=IDLE, imem_req=0, imem_addr=0, inst=NOP_INST, inst_valid=0, fetch_err=0, drop_q=0 and counter=0.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction; a response arriving after reset release SHALL be ignored.

Verification
REQ-040 Reset, pc=0x100, fetch_en=1, gnt same cycle, rvalid next cycle with rdata=0x00500093 -> imem_addr=0x100, inst=0x00500093, inst_valid high in cycle 3, fetch_err=0.
REQ-041 Hold inst_ready=0 for 5 cycles, then pulse it with fetch_en=1 and pc=0x104 -> inst stable for 5 cycles, next imem_req with imem_addr=0x104 on the following cycle.
REQ-042 pc=0x102 -> no imem_req, inst=0x00000013, fetch_err=1, inst_valid=1.
REQ-043 Grant, then no rvalid for 16 cycles -> inst=NOP_INST, fetch_err=1; a late rvalid is ignored.
REQ-044 Flush in WAIT, rvalid 2 cycles later with rdata=0xDEADBEEF -> inst_valid never rises, state IDLE; next fetch returns correct data.
REQ-045 rst low during WAIT -> all outputs at reset values immediately; a post-reset rvalid produces no inst_valid.
